// File: rtl/id_ex_ctrl_stage.sv
// rtl/id_ex_ctrl_stage.sv - ID/EX decode and control pipeline register for the RV32I core
// Decodes id_inst, detects load-use hazards and registers the EX-stage controls.
module id_ex_ctrl_stage #(
   parameter int XLEN     = 32,
   parameter bit FULL_ISA = 1'b1,
   parameter int CNT_W    = 8
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst_n,
   input  logic [31:0]      id_inst,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  pc_id,
   input  logic             flush,
   input  logic             ex_hold,
   output logic             stall_id,
   output logic             ex_valid,
   output logic [1:0]       ex_wd_sel,
   output logic [3:0]       ex_alu_op,
   output logic             ex_alua_sel,
   output logic             ex_alub_sel,
   output logic [2:0]       ex_sext_op,
   output logic             ex_rf_we,
   output logic             ex_dram_we,
   output logic             ex_is_load,
   output logic [2:0]       ex_mem_f3,
   output logic [3:0]       ex_branch,
   output logic [1:0]       ex_jump,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [XLEN-1:0]  ex_pc,
   output logic [CNT_W-1:0] illegal_cnt
);
   localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23, OP_BR = 7'h63;
   localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic [4:0] rs1_f, rs2_f, rd_f;
   logic       legal, use_rs1, use_rs2, use_rd;
   logic [1:0] d_wd_sel;
   logic [3:0] d_alu_op;
   logic [2:0] d_sext_op;
   logic       d_alua, d_alub, d_load, d_store, d_branch, d_jal, d_jalr;
   logic       hz_rs1, hz_rs2, load_use, take, count_ill;

   assign opcode = id_inst[6:0];
   assign rd_f   = id_inst[11:7];
   assign f3     = id_inst[14:12];
   assign rs1_f  = id_inst[19:15];
   assign rs2_f  = id_inst[24:20];
   assign f7     = id_inst[31:25];

   always_comb begin
      legal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
      d_wd_sel = 2'd0; d_alu_op = ALU_ADD; d_sext_op = 3'd0;
      d_alua = 1'b0; d_alub = 1'b0; d_load = 1'b0; d_store = 1'b0;
      d_branch = 1'b0; d_jal = 1'b0; d_jalr = 1'b0;
      case (opcode)
         OP_R: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            if (f7 == 7'h00) begin
               legal = 1'b1;
               case (f3)
                  3'd0: d_alu_op = ALU_ADD;
                  3'd1: d_alu_op = ALU_SLL;
                  3'd2: begin d_alu_op = ALU_SLT;  legal = FULL_ISA; end
                  3'd3: begin d_alu_op = ALU_SLTU; legal = FULL_ISA; end
                  3'd4: d_alu_op = ALU_XOR;
                  3'd5: d_alu_op = ALU_SRL;
                  3'd6: d_alu_op = ALU_OR;
                  3'd7: d_alu_op = ALU_AND;
               endcase
            end else if (f7 == 7'h20) begin
               legal    = (f3 == 3'd0) || (f3 == 3'd5);
               d_alu_op = (f3 == 3'd5) ? ALU_SRA : ALU_SUB;
            end
         end
         OP_I: begin
            use_rs1 = 1'b1; use_rd = 1'b1; d_alub = 1'b1; legal = 1'b1;
            case (f3)
               3'd0: d_alu_op = ALU_ADD;
               3'd1: begin d_alu_op = ALU_SLL; d_sext_op = 3'd1; legal = (f7 == 7'h00); end
               3'd2: begin d_alu_op = ALU_SLT;  legal = FULL_ISA; end
               3'd3: begin d_alu_op = ALU_SLTU; legal = FULL_ISA; end
               3'd4: d_alu_op = ALU_XOR;
               3'd5: begin
                  d_alu_op  = f7[5] ? ALU_SRA : ALU_SRL;
                  d_sext_op = 3'd1;
                  legal     = (f7 == 7'h00) || (f7 == 7'h20);
               end
               3'd6: d_alu_op = ALU_OR;
               3'd7: d_alu_op = ALU_AND;
            endcase
         end
         OP_LD: begin
            use_rs1 = 1'b1; use_rd = 1'b1; d_alub = 1'b1; d_wd_sel = 2'd1; d_load = 1'b1;
            legal = (f3 == 3'd2) || (FULL_ISA && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5));
         end
         OP_ST: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; d_alub = 1'b1; d_sext_op = 3'd2; d_store = 1'b1;
            legal = (f3 == 3'd2) || (FULL_ISA && (f3 == 3'd0 || f3 == 3'd1));
         end
         OP_BR: begin
            // unsigned compares go through SLTU, everything else through SUB
            use_rs1 = 1'b1; use_rs2 = 1'b1; d_sext_op = 3'd3; d_branch = 1'b1;
            d_alu_op = f3[1] ? ALU_SLTU : ALU_SUB;
            legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) || (FULL_ISA && f3[2:1] == 2'b11);
         end
         OP_LUI: begin
            use_rd = 1'b1; d_wd_sel = 2'd2; d_sext_op = 3'd4; legal = 1'b1;
         end
         OP_AUIPC: begin
            use_rd = 1'b1; d_alua = 1'b1; d_alub = 1'b1; d_sext_op = 3'd4; legal = FULL_ISA;
         end
         OP_JAL: begin
            use_rd = 1'b1; d_wd_sel = 2'd3; d_sext_op = 3'd5; d_jal = 1'b1; legal = 1'b1;
         end
         OP_JALR: begin
            use_rs1 = 1'b1; use_rd = 1'b1; d_alub = 1'b1; d_wd_sel = 2'd3; d_jalr = 1'b1;
            legal = (f3 == 3'd0);
         end
         default: legal = 1'b0;
      endcase
   end

   // hazard operand usage follows the opcode alone, regardless of legality
   assign hz_rs1   = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   assign hz_rs2   = (opcode == OP_R || opcode == OP_ST || opcode == OP_BR);
   assign load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
                     ((hz_rs1 && rs1_f == ex_rd) || (hz_rs2 && rs2_f == ex_rd));
   assign stall_id  = ex_hold || (load_use && !flush);
   assign take      = !flush && !load_use && id_valid && legal;
   assign count_ill = !flush && !load_use && id_valid && !legal && (illegal_cnt != {CNT_W{1'b1}});

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         ex_valid <= 1'b0; ex_wd_sel <= 2'd0; ex_alu_op <= 4'd0; ex_alua_sel <= 1'b0;
         ex_alub_sel <= 1'b0; ex_sext_op <= 3'd0; ex_rf_we <= 1'b0; ex_dram_we <= 1'b0;
         ex_is_load <= 1'b0; ex_mem_f3 <= 3'd0; ex_branch <= 4'd0; ex_jump <= 2'd0;
         ex_rs1 <= 5'd0; ex_rs2 <= 5'd0; ex_rd <= 5'd0; ex_pc <= '0; illegal_cnt <= '0;
      end else if (!ex_hold) begin
         ex_valid    <= take;
         ex_wd_sel   <= take ? d_wd_sel : 2'd0;
         ex_alu_op   <= take ? d_alu_op : 4'd0;
         ex_alua_sel <= take && d_alua;
         ex_alub_sel <= take && d_alub;
         ex_sext_op  <= take ? d_sext_op : 3'd0;
         ex_rf_we    <= take && use_rd && (rd_f != 5'd0);
         ex_dram_we  <= take && d_store;
         ex_is_load  <= take && d_load;
         ex_mem_f3   <= (take && (d_load || d_store)) ? f3 : 3'd0;
         ex_branch   <= (take && d_branch) ? {1'b1, f3} : 4'd0;
         ex_jump     <= take ? {d_jal, d_jalr} : 2'd0;
         ex_rs1      <= (take && use_rs1) ? rs1_f : 5'd0;
         ex_rs2      <= (take && use_rs2) ? rs2_f : 5'd0;
         ex_rd       <= (take && use_rd) ? rd_f : 5'd0;
         ex_pc       <= pc_id;
         if (count_ill) illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb/tb_id_ex_ctrl_stage.sv - bench for id_ex_ctrl_stage (full ISA and miniRV/2-bit counter instances)
// Directed vector table plus random traffic against an instruction-pattern reference model.
module tb_id_ex_ctrl_stage;
   typedef struct packed {
      logic valid; logic [1:0] wd_sel; logic [3:0] alu_op; logic alua; logic alub; logic [2:0] sext;
      logic rf_we; logic dram_we; logic is_load; logic [2:0] mem_f3; logic [3:0] branch; logic [1:0] jump;
      logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic [31:0] pc;
   } ctrl_t;
   typedef enum logic [3:0] {C_R, C_IALU, C_ISH, C_LD, C_ST, C_BR, C_LUI, C_AUIPC, C_JAL, C_JALR} cls_t;
   typedef struct packed { logic [31:0] mask; logic [31:0] match; logic full_only; cls_t cls; logic [3:0] alu; } pat_t;
   typedef struct {
      logic [31:0] inst; bit vld; bit fl; bit hd; bit stall; bit valid; logic [1:0] wd; logic [3:0] alu;
      bit alua; bit alub; logic [2:0] sext; bit we; bit ld; logic [2:0] f3; logic [4:0] rd; bit bv; logic [1:0] bc;
   } vec_t;

   localparam int NPAT = 37;
   localparam logic [31:0] MR = 32'hFE00707F, MI = 32'h0000707F, MU = 32'h0000007F;
   localparam logic [31:0] LW = 32'h0000A283, ADD = 32'h00228333, SUB = 32'h402081B3, AUIPC = 32'h00001097;

   logic cpu_clk, cpu_rst_n, id_valid, flush, ex_hold;
   logic [31:0] id_inst, pc_id;
   logic a_stall, a_valid, a_alua, a_alub, a_we, a_dwe, a_ld;
   logic b_stall, b_valid, b_alua, b_alub, b_we, b_dwe, b_ld;
   logic [1:0] a_wd, b_wd, a_jump, b_jump, b_cnt;
   logic [3:0] a_alu, b_alu, a_br, b_br;
   logic [2:0] a_sext, b_sext, a_f3, b_f3;
   logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
   logic [31:0] a_pc, b_pc;
   logic [7:0] a_cnt;
   ctrl_t act_a, act_b, st_a, st_b;
   int cnt_a, cnt_b, n_tests, n_fail;
   logic [31:0] pc_next;
   pat_t pats [NPAT];
   vec_t vq [$];

   assign act_a = {a_valid, a_wd, a_alu, a_alua, a_alub, a_sext, a_we, a_dwe, a_ld, a_f3, a_br, a_jump, a_rs1, a_rs2, a_rd, a_pc};
   assign act_b = {b_valid, b_wd, b_alu, b_alua, b_alub, b_sext, b_we, b_dwe, b_ld, b_f3, b_br, b_jump, b_rs1, b_rs2, b_rd, b_pc};

   id_ex_ctrl_stage dut_a (
      .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .id_inst(id_inst), .id_valid(id_valid), .pc_id(pc_id),
      .flush(flush), .ex_hold(ex_hold), .stall_id(a_stall), .ex_valid(a_valid), .ex_wd_sel(a_wd),
      .ex_alu_op(a_alu), .ex_alua_sel(a_alua), .ex_alub_sel(a_alub), .ex_sext_op(a_sext), .ex_rf_we(a_we),
      .ex_dram_we(a_dwe), .ex_is_load(a_ld), .ex_mem_f3(a_f3), .ex_branch(a_br), .ex_jump(a_jump),
      .ex_rs1(a_rs1), .ex_rs2(a_rs2), .ex_rd(a_rd), .ex_pc(a_pc), .illegal_cnt(a_cnt));

   id_ex_ctrl_stage #(.XLEN(32), .FULL_ISA(1'b0), .CNT_W(2)) dut_b (
      .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .id_inst(id_inst), .id_valid(id_valid), .pc_id(pc_id),
      .flush(flush), .ex_hold(ex_hold), .stall_id(b_stall), .ex_valid(b_valid), .ex_wd_sel(b_wd),
      .ex_alu_op(b_alu), .ex_alua_sel(b_alua), .ex_alub_sel(b_alub), .ex_sext_op(b_sext), .ex_rf_we(b_we),
      .ex_dram_we(b_dwe), .ex_is_load(b_ld), .ex_mem_f3(b_f3), .ex_branch(b_br), .ex_jump(b_jump),
      .ex_rs1(b_rs1), .ex_rs2(b_rs2), .ex_rd(b_rd), .ex_pc(b_pc), .illegal_cnt(b_cnt));

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic ctrl_t model_decode(input logic [31:0] inst, input bit full, output bit ill);
      ctrl_t c;
      int hit;
      c = '0;
      hit = -1;
      for (int k = 0; k < NPAT; k++)
         if ((inst & pats[k].mask) == pats[k].match && (full || !pats[k].full_only)) hit = k;
      ill = (hit < 0);
      if (hit >= 0) begin
         c.valid = 1'b1;
         c.alu_op = pats[hit].alu;
         case (pats[hit].cls)
            C_R:     begin c.rs1 = inst[19:15]; c.rs2 = inst[24:20]; c.rd = inst[11:7]; end
            C_IALU:  begin c.alub = 1'b1; c.rs1 = inst[19:15]; c.rd = inst[11:7]; end
            C_ISH:   begin c.alub = 1'b1; c.sext = 3'd1; c.rs1 = inst[19:15]; c.rd = inst[11:7]; end
            C_LD:    begin c.alub = 1'b1; c.wd_sel = 2'd1; c.is_load = 1'b1; c.mem_f3 = inst[14:12];
                           c.rs1 = inst[19:15]; c.rd = inst[11:7]; end
            C_ST:    begin c.alub = 1'b1; c.sext = 3'd2; c.dram_we = 1'b1; c.mem_f3 = inst[14:12];
                           c.rs1 = inst[19:15]; c.rs2 = inst[24:20]; end
            C_BR:    begin c.sext = 3'd3; c.branch = {1'b1, inst[14:12]}; c.rs1 = inst[19:15]; c.rs2 = inst[24:20]; end
            C_LUI:   begin c.wd_sel = 2'd2; c.sext = 3'd4; c.rd = inst[11:7]; end
            C_AUIPC: begin c.alua = 1'b1; c.alub = 1'b1; c.sext = 3'd4; c.rd = inst[11:7]; end
            C_JAL:   begin c.wd_sel = 2'd3; c.sext = 3'd5; c.jump = 2'b10; c.rd = inst[11:7]; end
            default: begin c.wd_sel = 2'd3; c.alub = 1'b1; c.jump = 2'b01; c.rs1 = inst[19:15]; c.rd = inst[11:7]; end
         endcase
         c.rf_we = (c.rd != 5'd0);
      end
      return c;
   endfunction

   function automatic bit model_load_use(input ctrl_t st, input logic [31:0] inst, input bit vld);
      logic [6:0] op;
      bit r1, r2;
      op = inst[6:0];
      r1 = !(op inside {7'h37, 7'h17, 7'h6F});
      r2 = op inside {7'h33, 7'h23, 7'h63};
      return vld && st.valid && st.is_load && st.rd != 5'd0 &&
             ((r1 && inst[19:15] == st.rd) || (r2 && inst[24:20] == st.rd));
   endfunction

   function automatic void model_next(inout ctrl_t st, inout int cnt, input int cmax, input bit full,
         input logic [31:0] inst, input logic [31:0] pc, input bit vld, input bit fl, input bit lu);
      ctrl_t d;
      bit ill;
      d = model_decode(inst, full, ill);
      if (fl || lu || !vld) d = '0;
      d.pc = pc;
      if (!fl && !lu && vld && ill && cnt < cmax) cnt++;
      st = d;
   endfunction

   function automatic vec_t mk(input logic [31:0] inst, input bit vld, input bit fl, input bit hd, input bit stall,
         input bit va, input int wd, input int alu, input bit aa, input bit ab, input int sx, input bit we,
         input bit ld, input int f3, input int rd, input bit bv, input int bc);
      vec_t r;
      r.inst = inst; r.vld = vld; r.fl = fl; r.hd = hd; r.stall = stall; r.valid = va;
      r.wd = 2'(wd); r.alu = 4'(alu); r.alua = aa; r.alub = ab; r.sext = 3'(sx); r.we = we; r.ld = ld;
      r.f3 = 3'(f3); r.rd = 5'(rd); r.bv = bv; r.bc = 2'(bc);
      return r;
   endfunction

   task automatic model_reset();
      st_a = '0; st_b = '0; cnt_a = 0; cnt_b = 0;
   endtask

   task automatic cycle(input logic [31:0] inst, input bit vld, input bit fl, input bit hd, input int row);
      bit lu_a, lu_b;
      logic [31:0] pc;
      pc = pc_next;
      pc_next += 32'd4;
      id_inst = inst; id_valid = vld; flush = fl; ex_hold = hd; pc_id = pc;
      #1;
      lu_a = model_load_use(st_a, inst, vld);
      lu_b = model_load_use(st_b, inst, vld);
      chk("stall_a", 80'(a_stall), 80'(hd | (lu_a & ~fl)));
      chk("stall_b", 80'(b_stall), 80'(hd | (lu_b & ~fl)));
      if (row >= 0) chk($sformatf("tbl%0d_stall", row), 80'(a_stall), 80'(vq[row].stall));
      if (!hd) begin
         model_next(st_a, cnt_a, 255, 1'b1, inst, pc, vld, fl, lu_a);
         model_next(st_b, cnt_b, 3, 1'b0, inst, pc, vld, fl, lu_b);
      end
      @(posedge cpu_clk);
      #1;
      chk("ctrl_a", 80'(act_a), 80'(st_a));
      chk("cnt_a", 80'(a_cnt), 80'(cnt_a));
      chk("ctrl_b", 80'(act_b), 80'(st_b));
      chk("cnt_b", 80'(b_cnt), 80'(cnt_b));
      if (row >= 0) begin
         chk($sformatf("tbl%0d_a", row),
             80'({a_valid, a_wd, a_alu, a_alua, a_alub, a_sext, a_we, a_ld, a_f3, a_rd}),
             80'({vq[row].valid, vq[row].wd, vq[row].alu, vq[row].alua, vq[row].alub, vq[row].sext,
                  vq[row].we, vq[row].ld, vq[row].f3, vq[row].rd}));
         chk($sformatf("tbl%0d_b", row), 80'({b_valid, b_cnt}), 80'({vq[row].bv, vq[row].bc}));
      end
   endtask

   initial begin
      logic [31:0] ins;
      int k;
      pats = '{
         '{MR, 32'h00000033, 1'b0, C_R, 4'd0}, '{MR, 32'h40000033, 1'b0, C_R, 4'd1},
         '{MR, 32'h00001033, 1'b0, C_R, 4'd5}, '{MR, 32'h00002033, 1'b1, C_R, 4'd8},
         '{MR, 32'h00003033, 1'b1, C_R, 4'd9}, '{MR, 32'h00004033, 1'b0, C_R, 4'd4},
         '{MR, 32'h00005033, 1'b0, C_R, 4'd6}, '{MR, 32'h40005033, 1'b0, C_R, 4'd7},
         '{MR, 32'h00006033, 1'b0, C_R, 4'd3}, '{MR, 32'h00007033, 1'b0, C_R, 4'd2},
         '{MI, 32'h00000013, 1'b0, C_IALU, 4'd0}, '{MI, 32'h00002013, 1'b1, C_IALU, 4'd8},
         '{MI, 32'h00003013, 1'b1, C_IALU, 4'd9}, '{MI, 32'h00004013, 1'b0, C_IALU, 4'd4},
         '{MI, 32'h00006013, 1'b0, C_IALU, 4'd3}, '{MI, 32'h00007013, 1'b0, C_IALU, 4'd2},
         '{MR, 32'h00001013, 1'b0, C_ISH, 4'd5}, '{MR, 32'h00005013, 1'b0, C_ISH, 4'd6},
         '{MR, 32'h40005013, 1'b0, C_ISH, 4'd7},
         '{MI, 32'h00000003, 1'b1, C_LD, 4'd0}, '{MI, 32'h00001003, 1'b1, C_LD, 4'd0},
         '{MI, 32'h00002003, 1'b0, C_LD, 4'd0}, '{MI, 32'h00004003, 1'b1, C_LD, 4'd0},
         '{MI, 32'h00005003, 1'b1, C_LD, 4'd0},
         '{MI, 32'h00000023, 1'b1, C_ST, 4'd0}, '{MI, 32'h00001023, 1'b1, C_ST, 4'd0},
         '{MI, 32'h00002023, 1'b0, C_ST, 4'd0},
         '{MI, 32'h00000063, 1'b0, C_BR, 4'd1}, '{MI, 32'h00001063, 1'b0, C_BR, 4'd1},
         '{MI, 32'h00004063, 1'b0, C_BR, 4'd1}, '{MI, 32'h00005063, 1'b0, C_BR, 4'd1},
         '{MI, 32'h00006063, 1'b1, C_BR, 4'd9}, '{MI, 32'h00007063, 1'b1, C_BR, 4'd9},
         '{MU, 32'h00000037, 1'b0, C_LUI, 4'd0}, '{MU, 32'h00000017, 1'b1, C_AUIPC, 4'd0},
         '{MU, 32'h0000006F, 1'b0, C_JAL, 4'd0}, '{MI, 32'h00000067, 1'b0, C_JALR, 4'd0}};
      n_tests = 0; n_fail = 0; pc_next = 32'h100;
      model_reset();
      cpu_rst_n = 1'b0; id_inst = LW; id_valid = 1'b1; pc_id = 32'h40; flush = 1'b0; ex_hold = 1'b0;
      repeat (3) begin
         @(posedge cpu_clk);
         #1;
         chk("rst_ctrl_a", 80'(act_a), 80'(0));
         chk("rst_ctrl_b", 80'(act_b), 80'(0));
         chk("rst_cnt", 80'({a_cnt, b_cnt}), 80'(0));
         chk("rst_stall", 80'({a_stall, b_stall}), 80'(0));
      end
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;

      // rows 0-4: illegal words saturating the 2-bit counter
      for (int i = 0; i < 5; i++)
         vq.push_back(mk(32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i < 3) ? i + 1 : 3));
      vq.push_back(mk(LW,    1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 2, 5, 1, 0));
      vq.push_back(mk(ADD,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(ADD,   1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6, 1, 0));
      vq.push_back(mk(SUB,   1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 3, 1, 0));
      vq.push_back(mk(AUIPC, 1, 0, 0, 0, 1, 0, 0, 1, 1, 4, 1, 0, 0, 1, 0, 1));
      vq.push_back(mk(LW,    1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 2, 5, 1, 1));
      vq.push_back(mk(ADD,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vq.push_back(mk(LW,    1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 2, 5, 1, 1));
      vq.push_back(mk(ADD,   1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 2, 5, 1, 1));
      vq.push_back(mk(ADD,   1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 2, 5, 1, 1));
      vq.push_back(mk(ADD,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vq.push_back(mk(ADD,   1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6, 1, 1));
      vq.push_back(mk(SUB,   1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6, 1, 1));
      vq.push_back(mk(SUB,   1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 3, 1, 1));
      vq.push_back(mk(LW,    1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 2, 5, 1, 1));
      vq.push_back(mk(ADD,   1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 2, 5, 1, 1));
      vq.push_back(mk(ADD,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

      for (int i = 0; i < 5; i++) cycle(vq[i].inst, vq[i].vld, vq[i].fl, vq[i].hd, i);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b0;
      #2;
      cpu_rst_n = 1'b1;
      model_reset();
      for (int i = 5; i < vq.size(); i++) cycle(vq[i].inst, vq[i].vld, vq[i].fl, vq[i].hd, i);

      // reset asserted while the load-use stall is being signalled
      cycle(LW, 1, 0, 0, -1);
      id_inst = ADD; id_valid = 1'b1; flush = 1'b0; ex_hold = 1'b0;
      #1;
      chk("mid_pre_stall", 80'(a_stall), 80'(1));
      cpu_rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", 80'({a_stall, b_stall}), 80'(0));
      chk("mid_rst_valid", 80'({a_valid, b_valid}), 80'(0));
      #1;
      cpu_rst_n = 1'b1;
      model_reset();
      cycle(ADD, 1, 0, 0, -1);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            k = int'($urandom_range(0, NPAT - 1));
            ins = ($urandom() & ~pats[k].mask) | pats[k].match;
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
         end else begin
            ins = $urandom();
         end
         cycle(ins, $urandom_range(0, 9) < 9, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
